// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch geometry, the NOP word and the fetch FSM encoding.
package cpu_pkg;

    localparam int          PC_WIDTH_DEFAULT = 10;
    localparam int          RESET_PC_DEFAULT = 0;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_RESP = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding read per instruction, result held for decode
// until accepted; a redirect from execute/writeback overrides everything.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEFAULT,
    parameter int RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [PC_WIDTH-1:0] inst_pc,
    output logic [PC_WIDTH-1:0] inst_pc_plus4
);

    localparam logic [PC_WIDTH-1:0] PC_STEP   = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] WORD_MASK = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] PC_INIT   = PC_WIDTH'(RESET_PC);

    fetch_state_t        state;
    fetch_state_t        next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next_seq;

    assign pc_next_seq = pc + PC_STEP;
    assign imem_addr   = pc;

    // Illegal encodings fall back to REQ; a redirect always restarts fetching.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        case (state)
            ST_REQ: begin
                imem_req   = 1'b1;
                next_state = ST_RESP;
            end
            ST_RESP: next_state = ST_HOLD;
            ST_HOLD: begin
                if (inst_ready) begin
                    next_state = ST_REQ;
                end
            end
            default: next_state = ST_REQ;
        endcase
        if (redirect_valid) begin
            next_state = ST_REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_REQ;
            pc            <= PC_INIT;
            inst_valid    <= 1'b0;
            inst          <= NOP_WORD;
            inst_pc       <= '0;
            inst_pc_plus4 <= '0;
        end else begin
            state <= next_state;
            if (redirect_valid) begin
                pc         <= redirect_pc & WORD_MASK;
                inst_valid <= 1'b0;
            end else begin
                case (state)
                    ST_RESP: begin
                        inst          <= imem_data;
                        inst_pc       <= pc;
                        inst_pc_plus4 <= pc_next_seq;
                        inst_valid    <= 1'b1;
                        pc            <= pc_next_seq;
                    end
                    ST_HOLD: begin
                        if (inst_ready) begin
                            inst_valid <= 1'b0;
                        end
                    end
                    default: inst_valid <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the expected instruction stream.
module tb_ifetch_unit;

    localparam int PC_WIDTH = 10;
    localparam int RESET_PC = 0;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_data = 32'h0;
    logic                redirect_valid = 1'b0;
    logic [PC_WIDTH-1:0] redirect_pc = '0;
    logic                inst_valid;
    logic                inst_ready = 1'b1;
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] inst_pc;
    logic [PC_WIDTH-1:0] inst_pc_plus4;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    ifetch_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word returned the cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_data <= mem[imem_addr[9:2]];
    end

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_timeout: inst_valid=%b expected 1", name, inst_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, inst_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: req/valid=%b expected 10", {imem_req, inst_valid});
        end
        checks++;
        if ({inst, inst_pc, inst_pc_plus4, imem_addr} !== {32'h0, 10'd0, 10'd0, 10'(RESET_PC)}) begin
            errors++;
            $display("[TB] FAIL reset_regs: inst=%h pc=%h pc4=%h addr=%h expected 0/0/0/%h",
                     inst, inst_pc, inst_pc_plus4, imem_addr, 10'(RESET_PC));
        end
        do_reset();
    endtask

    task automatic test_first_fetch();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
            errors++;
            $display("[TB] FAIL first_req: req=%b addr=%h expected 1/000", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_resp: req=%b valid=%b expected 0/0", imem_req, inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h2008_0005 || inst_pc !== 10'd0 || inst_pc_plus4 !== 10'd4) begin
            errors++;
            $display("[TB] FAIL first_inst: valid=%b inst=%h pc=%h pc4=%h expected 1/20080005/000/004",
                     inst_valid, inst, inst_pc, inst_pc_plus4);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd4 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL second_req: req=%b addr=%h valid=%b expected 1/004/0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0]         held_inst;
        logic [PC_WIDTH-1:0] held_pc;
        inst_ready = 1'b0;
        wait_valid("stall");
        held_inst = inst;
        held_pc   = inst_pc;
        checks++;
        if (held_inst !== mem[1] || held_pc !== 10'd4) begin
            errors++;
            $display("[TB] FAIL stall_word: inst=%h pc=%h expected %h/004", held_inst, held_pc, mem[1]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst !== held_inst || inst_pc !== held_pc || imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: valid=%b inst=%h pc=%h req=%b expected 1/%h/%h/0",
                         i, inst_valid, inst, inst_pc, imem_req, held_inst, held_pc);
            end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd8 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: req=%b addr=%h valid=%b expected 1/008/0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_redirect_resp();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_resp_phase: req=%b valid=%b expected 0/0", imem_req, inst_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 10'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h100 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_resp_req: req=%b addr=%h valid=%b expected 1/100/0",
                     imem_req, imem_addr, inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_resp_drop: valid=%b expected 0", inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h100 || inst !== mem[8'h40]) begin
            errors++;
            $display("[TB] FAIL redir_resp_inst: valid=%b pc=%h inst=%h expected 1/100/%h",
                     inst_valid, inst_pc, inst, mem[8'h40]);
        end
    endtask

    task automatic test_back_to_back();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 10'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h200) begin
            errors++;
            $display("[TB] FAIL b2b_redirect: valid=%b req=%b addr=%h expected 0/1/200",
                     inst_valid, imem_req, imem_addr);
        end
        wait_valid("b2b");
        checks++;
        if (inst_pc !== 10'h200 || inst !== mem[8'h80]) begin
            errors++;
            $display("[TB] FAIL b2b_inst: pc=%h inst=%h expected 200/%h", inst_pc, inst, mem[8'h80]);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 10'd1020;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid("wrap");
        checks++;
        if (inst_pc !== 10'd1020 || inst_pc_plus4 !== 10'd0 || inst !== mem[255]) begin
            errors++;
            $display("[TB] FAIL wrap_inst: pc=%0d pc4=%0d inst=%h expected 1020/0/%h",
                     inst_pc, inst_pc_plus4, inst, mem[255]);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
            errors++;
            $display("[TB] FAIL wrap_next: req=%b addr=%h expected 1/000", imem_req, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_pc !== 10'd1020) begin
            errors++;
            $display("[TB] FAIL areset_setup: req=%b pc=%0d expected 0/1020", imem_req, inst_pc);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({inst_valid, inst, inst_pc, inst_pc_plus4} !== {1'b0, 32'h0, 10'd0, 10'd0} ||
            imem_req !== 1'b1 || imem_addr !== 10'(RESET_PC)) begin
            errors++;
            $display("[TB] FAIL areset_clear: valid=%b inst=%h pc=%h pc4=%h req=%b addr=%h expected 0/0/0/0/1/%h",
                     inst_valid, inst, inst_pc, inst_pc_plus4, imem_req, imem_addr, 10'(RESET_PC));
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'(RESET_PC)) begin
            errors++;
            $display("[TB] FAIL areset_req: req=%b addr=%h expected 1/%h", imem_req, imem_addr, 10'(RESET_PC));
        end
        wait_valid("areset");
        checks++;
        if (inst_pc !== 10'(RESET_PC) || inst !== mem[RESET_PC / 4]) begin
            errors++;
            $display("[TB] FAIL areset_inst: pc=%h inst=%h expected %h/%h",
                     inst_pc, inst, 10'(RESET_PC), mem[RESET_PC / 4]);
        end
    endtask

    // Model: the address of the next instruction decode should see; it advances on a
    // transfer and jumps on a redirect. No decode-visible gap may exceed two cycles.
    task automatic test_random();
        logic [PC_WIDTH-1:0] exp_pc;
        int gap = 0;
        do_reset();
        exp_pc = 10'(RESET_PC);
        for (int c = 0; c < 600; c++) begin
            if (imem_req) begin
                checks++;
                if (imem_addr !== exp_pc) begin
                    errors++;
                    $display("[TB] FAIL rand_req_addr c%0d: addr=%h expected %h", c, imem_addr, exp_pc);
                end
            end
            if (inst_valid) begin
                gap = 0;
                checks++;
                if (inst_pc !== exp_pc || inst_pc_plus4 !== exp_pc + 10'd4 || inst !== mem[exp_pc[9:2]]) begin
                    errors++;
                    $display("[TB] FAIL rand_inst c%0d: pc=%h pc4=%h inst=%h expected %h/%h/%h",
                             c, inst_pc, inst_pc_plus4, inst, exp_pc, exp_pc + 10'd4, mem[exp_pc[9:2]]);
                end
            end else begin
                gap++;
                if (gap > 2) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rand_gap c%0d: invalid_cycles=%0d expected <=2", c, gap);
                end
            end
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 10'($urandom);
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~10'd3;
                gap = 0;
            end else if (inst_valid && inst_ready) begin
                exp_pc = exp_pc + 10'd4;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        $display("[TB] starting ifetch_unit bench");
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_resp();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
